// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD arbiter slice: default operand width and FSM state codes.
package gcd_pkg;

    localparam int GCD_W = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_BUSY  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] grant_o,
    output logic          any_o
);

    // Scan from the farthest candidate back to ptr so the closest hit wins.
    always_comb begin
        grant_o = '0;
        any_o   = |req_i;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                grant_o = PW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one GCD engine among N requesters, one operation in flight,
// with a bypass for x==0, y!=0 operands that a subtractive engine could never finish.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int N = 4,
    parameter int W = GCD_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N-1:0]     req_valid_i,
    input  logic [N*2*W-1:0] req_data_i,
    output logic [N-1:0]     req_ready_o,
    output logic [N-1:0]     resp_valid_o,
    output logic [W-1:0]     resp_data_o,
    input  logic [N-1:0]     resp_ready_i,
    output logic             gcd_in_valid_o,
    output logic [2*W-1:0]   gcd_in_data_o,
    input  logic             gcd_in_ready_i,
    input  logic             gcd_out_valid_i,
    input  logic [W-1:0]     gcd_out_data_i
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [2*W-1:0] op_q, op_d;
    logic [W-1:0]   result_q, result_d;

    logic [PW-1:0]  grant;
    logic           anyReq;
    logic [2*W-1:0] grantData;
    logic [W-1:0]   grantX;
    logic [W-1:0]   grantY;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .any_o   (anyReq)
    );

    always_comb begin
        grantData = '0;
        for (int i = 0; i < N; i++) begin
            if (PW'(i) == grant) begin
                grantData = req_data_i[i*2*W +: 2*W];
            end
        end
    end

    assign grantX = grantData[W-1:0];
    assign grantY = grantData[2*W-1:W];

    // Accept is combinational so a request can be taken in the same IDLE cycle it appears.
    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_IDLE && anyReq && !reset_i) begin
            req_ready_o[grant] = 1'b1;
        end
    end

    always_comb begin
        resp_valid_o = '0;
        if (state_q == ST_RESP) begin
            resp_valid_o[owner_q] = 1'b1;
        end
    end

    assign resp_data_o    = result_q;
    assign gcd_in_valid_o = (state_q == ST_ISSUE);
    assign gcd_in_data_o  = op_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    op_d    = grantData;
                    owner_d = grant;
                    ptr_d   = (grant == PW'(N - 1)) ? '0 : grant + PW'(1);
                    if (grantX == '0 && grantY != '0) begin
                        result_d = grantY;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (gcd_in_ready_i) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (gcd_out_valid_i) begin
                    result_d = gcd_out_data_i;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural GCD engine plus a transaction-level model of
// round-robin grant order, result values and response timing.
module tb_gcd_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     reqValid;
    logic [N*2*W-1:0] reqData;
    logic [N-1:0]     reqReady;
    logic [N-1:0]     respValid;
    logic [W-1:0]     respData;
    logic [N-1:0]     respReady;
    logic             gcdInValid;
    logic [2*W-1:0]   gcdInData;
    logic             gcdInReady;
    logic             gcdOutValid;
    logic [W-1:0]     gcdOutData;

    logic           engBusy, engOutValid;
    logic [W-1:0]   engOutData, engRes;
    int             engCnt;
    int             engLat;
    logic           strayValid;
    logic [W-1:0]   strayData;

    int             testsRun, testsFailed;
    bit [N-1:0]     reqV;
    logic [W-1:0]   reqX [N];
    logic [W-1:0]   reqY [N];
    logic [N-1:0]   respMask;
    bit             holdReqs, strayReq, inFlight, mBypass, issued, respPending;
    int             mPtr, mOwner, acceptCyc, engDoneCyc, cycle, opsDone;
    logic [2*W-1:0] mOp;
    logic [W-1:0]   mExp, lastResult, lastRespData;
    logic [W-1:0]   respByOwner [N];
    int             waitOps [N];
    int             grantLog [$];

    always #5 clk = ~clk;

    gcd_arbiter #(.N(N), .W(W)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .req_valid_i     (reqValid),
        .req_data_i      (reqData),
        .req_ready_o     (reqReady),
        .resp_valid_o    (respValid),
        .resp_data_o     (respData),
        .resp_ready_i    (respReady),
        .gcd_in_valid_o  (gcdInValid),
        .gcd_in_data_o   (gcdInData),
        .gcd_in_ready_i  (gcdInReady),
        .gcd_out_valid_i (gcdOutValid),
        .gcd_out_data_i  (gcdOutData)
    );

    function automatic logic [W-1:0] gcdRef(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned u, v, t;
        u = a;
        v = b;
        while (v != 0) begin
            t = u % v;
            u = v;
            v = t;
        end
        return W'(u);
    endfunction

    // Engine stand-in: idle until handed operands, then one result pulse after engLat+1 cycles.
    assign gcdInReady  = !engBusy;
    assign gcdOutValid = engOutValid | strayValid;
    assign gcdOutData  = strayValid ? strayData : engOutData;

    always @(posedge clk) begin
        if (reset) begin
            engBusy     <= 1'b0;
            engOutValid <= 1'b0;
            engOutData  <= '0;
            engRes      <= '0;
            engCnt      <= 0;
        end else begin
            engOutValid <= 1'b0;
            if (engBusy) begin
                if (engCnt == 0) begin
                    engOutValid <= 1'b1;
                    engOutData  <= engRes;
                    engBusy     <= 1'b0;
                end else begin
                    engCnt <= engCnt - 1;
                end
            end else if (gcdInValid) begin
                engBusy <= 1'b1;
                engCnt  <= engLat;
                engRes  <= gcdRef(gcdInData[W-1:0], gcdInData[2*W-1:W]);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        reqValid   = reqV;
        for (int i = 0; i < N; i++) reqData[i*2*W +: 2*W] = {reqY[i], reqX[i]};
        respReady  = respMask;
        strayValid = strayReq;
    endtask

    task automatic setReq(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        reqV[i]    = 1'b1;
        reqX[i]    = x;
        reqY[i]    = y;
        waitOps[i] = 0;
    endtask

    function automatic int pickRef();
        for (int k = 0; k < N; k++) begin
            if (reqV[(mPtr + k) % N]) return (mPtr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] randOperand();
        if ($urandom_range(0, 9) == 0) return '0;
        return W'($urandom_range(1, 60) * $urandom_range(1, 40));
    endfunction

    // One clock of stimulus, then every observable output checked against the transaction model.
    task automatic runCycle();
        logic [N-1:0] respExp, reqExp;
        bit           was;
        int           g;
        @(negedge clk);
        applyStimulus();
        #1;
        was     = inFlight;
        respExp = '0;
        if (inFlight && (mBypass ? (cycle > acceptCyc) : (engDoneCyc >= 0 && cycle > engDoneCyc))) begin
            respExp[mOwner] = 1'b1;
            lastResult      = mExp;
        end
        respPending = (respExp != '0);
        checkOutput("resp_valid", 32'(respValid), 32'(respExp));
        checkOutput("resp_data", 32'(respData), 32'(lastResult));
        if (respPending && respReady[mOwner]) begin
            inFlight            = 1'b0;
            lastRespData        = respData;
            respByOwner[mOwner] = respData;
            opsDone++;
        end
        if (was && !mBypass && !issued && cycle == acceptCyc + 1)
            checkOutput("gcd_in_valid_t1", 32'(gcdInValid), 32'd1);
        if (gcdInValid) begin
            checkOutput("gcd_in_legal", 32'(was && !mBypass && !issued), 32'd1);
            checkOutput("gcd_in_data", gcdInData, mOp);
            if (gcdInReady) issued = 1'b1;
        end
        if (was && issued && engOutValid && engDoneCyc < 0) engDoneCyc = cycle;
        reqExp = '0;
        g      = pickRef();
        if (!was && g >= 0) reqExp[g] = 1'b1;
        checkOutput("req_ready", 32'(reqReady), 32'(reqExp));
        if (reqExp != '0) begin
            inFlight   = 1'b1;
            mOwner     = g;
            mOp        = {reqY[g], reqX[g]};
            mExp       = gcdRef(reqX[g], reqY[g]);
            mBypass    = (reqX[g] == '0 && reqY[g] != '0);
            acceptCyc  = cycle;
            issued     = 1'b0;
            engDoneCyc = -1;
            mPtr       = (g + 1) % N;
            grantLog.push_back(g);
            for (int i = 0; i < N; i++) begin
                if (i != g && reqV[i]) begin
                    waitOps[i]++;
                    checkOutput("fairness", 32'(waitOps[i] < N), 32'd1);
                end
            end
            waitOps[g] = 0;
            if (!holdReqs) reqV[g] = 1'b0;
        end
        strayReq = 1'b0;
        cycle++;
    endtask

    task automatic runUntil(input int target, input int budget, input string tag);
        int n = 0;
        while (opsDone < target && n < budget) begin
            runCycle();
            n++;
        end
        checkOutput(tag, 32'(opsDone >= target), 32'd1);
    endtask

    task automatic waitResp(input int owner, input int budget, input string tag);
        int n = 0;
        while (!(respPending && mOwner == owner) && n < budget) begin
            runCycle();
            n++;
        end
        checkOutput(tag, 32'(respPending && mOwner == owner), 32'd1);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset    = 1'b1;
        reqV     = '0;
        respMask = '1;
        strayReq = 1'b0;
        applyStimulus();
        @(negedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
        checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
        checkOutput("rst_gcd_in_valid", 32'(gcdInValid), 32'd0);
        checkOutput("rst_gcd_in_data", gcdInData, 32'd0);
        checkOutput("rst_resp_data", 32'(respData), 32'd0);
        reset       = 1'b0;
        inFlight    = 1'b0;
        issued      = 1'b0;
        respPending = 1'b0;
        mPtr        = 0;
        lastResult  = '0;
        engDoneCyc  = -1;
        grantLog.delete();
    endtask

    initial begin
        int target, n;
        testsRun = 0; testsFailed = 0;
        reqV = '0; respMask = '1; holdReqs = 0; strayReq = 0; strayData = '0;
        inFlight = 0; mBypass = 0; issued = 0; respPending = 0;
        mPtr = 0; mOwner = 0; acceptCyc = 0; engDoneCyc = -1; cycle = 0; opsDone = 0;
        mOp = '0; mExp = '0; lastResult = '0; lastRespData = '0; engLat = 2;
        for (int i = 0; i < N; i++) begin
            reqX[i] = '0; reqY[i] = '0; respByOwner[i] = '0; waitOps[i] = 0;
        end
        applyStimulus();
        doReset();

        // Single request; a second one from the same requester waits out the response.
        setReq(0, 16'd18, 16'd48);
        respMask = '0;
        waitResp(0, 50, "single_resp_timeout");
        setReq(0, 16'd100, 16'd75);
        respMask = '1;
        runUntil(opsDone + 1, 10, "single_timeout");
        checkOutput("single_result", 32'(lastRespData), 32'd6);
        runUntil(opsDone + 1, 50, "second_timeout");
        checkOutput("second_result", 32'(lastRespData), 32'd25);

        // All four requesters held valid from a fresh pointer.
        doReset();
        holdReqs = 1;
        setReq(0, 16'd12, 16'd8);
        setReq(1, 16'd9, 16'd6);
        setReq(2, 16'd35, 16'd14);
        setReq(3, 16'd7, 16'd7);
        runUntil(opsDone + 8, 200, "rr_timeout");
        holdReqs = 0;
        reqV     = '0;
        checkOutput("rr_count", 32'(grantLog.size()), 32'd8);
        for (int i = 0; i < grantLog.size() && i < 8; i++) checkOutput("rr_order", 32'(grantLog[i]), 32'(i % N));
        checkOutput("rr_res0", 32'(respByOwner[0]), 32'd4);
        checkOutput("rr_res1", 32'(respByOwner[1]), 32'd3);
        checkOutput("rr_res2", 32'(respByOwner[2]), 32'd7);
        checkOutput("rr_res3", 32'(respByOwner[3]), 32'd7);

        // Bypass for x==0, then x==y==0 through the engine.
        setReq(2, 16'd0, 16'd25);
        runUntil(opsDone + 1, 20, "bypass_timeout");
        checkOutput("bypass_result", 32'(lastRespData), 32'd25);
        checkOutput("bypass_no_engine", 32'(issued), 32'd0);
        setReq(3, 16'd0, 16'd0);
        runUntil(opsDone + 1, 50, "zero_timeout");
        checkOutput("zero_result", 32'(lastRespData), 32'd0);
        checkOutput("zero_via_engine", 32'(issued), 32'd1);

        // Back-pressure on requester 1 while others wait.
        setReq(1, randOperand() | 16'd1, randOperand() | 16'd1);
        setReq(0, 16'd21, 16'd14);
        setReq(2, 16'd64, 16'd48);
        respMask = 4'b1101;
        waitResp(1, 200, "bp_resp_timeout");
        repeat (10) runCycle();
        checkOutput("bp_hold_valid", 32'(respValid), 32'b0010);
        respMask = '1;
        runUntil(opsDone + 1 + $countones(reqV), 200, "bp_drain_timeout");

        // Stray engine pulses in IDLE and in RESP.
        strayReq = 1; strayData = 16'hBEEF;
        runCycle();
        runCycle();
        setReq(3, 16'd40, 16'd24);
        respMask = '0;
        waitResp(3, 50, "stray_resp_timeout");
        strayReq = 1; strayData = 16'h1234;
        runCycle();
        runCycle();
        checkOutput("stray_resp_data", 32'(respData), 32'd8);
        respMask = '1;
        runUntil(opsDone + 1, 10, "stray_drain_timeout");
        checkOutput("stray_result", 32'(lastRespData), 32'd8);

        // Randomised traffic, latencies and response stalls.
        target = opsDone + 40;
        n = 0;
        while (opsDone < target && n < 4000) begin
            for (int i = 0; i < N; i++) begin
                if (!reqV[i] && $urandom_range(0, 3) == 0) setReq(i, randOperand(), randOperand());
            end
            respMask = 4'($urandom);
            engLat   = $urandom_range(0, 5);
            if ((!inFlight || respPending) && $urandom_range(0, 7) == 0) begin
                strayReq  = 1;
                strayData = 16'($urandom);
            end
            runCycle();
            n++;
        end
        checkOutput("random_timeout", 32'(opsDone >= target), 32'd1);

        // Reset in BUSY, then service restarts with the pointer at 0.
        doReset();
        engLat = 8;
        setReq(2, 16'd30, 16'd12);
        n = 0;
        while (!issued && n < 20) begin
            runCycle();
            n++;
        end
        checkOutput("busy_reached", 32'(issued), 32'd1);
        runCycle();
        doReset();
        engLat = 2;
        setReq(3, 16'd27, 16'd18);
        setReq(0, 16'd50, 16'd20);
        runUntil(opsDone + 2, 100, "post_reset_timeout");
        checkOutput("post_reset_count", 32'(grantLog.size()), 32'd2);
        if (grantLog.size() >= 2) begin
            checkOutput("post_reset_first", 32'(grantLog[0]), 32'd0);
            checkOutput("post_reset_second", 32'(grantLog[1]), 32'd3);
        end
        checkOutput("post_reset_result", 32'(lastRespData), 32'd9);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
